// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register for the pipelined RISC-V core.
//
// Captures the decode-stage control bundle, operands, immediate, PC and
// register indices, and presents them to the execute stage one cycle later.
// Supports hold (stall), bubble insertion (flush) and, when the macro
// ID_EX_LOAD_USE_EN is defined, load-use hazard detection with automatic
// bubble insertion.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   stall, flush          hold stage contents / replace next contents with a bubble
//   id_valid, id_*        decode-stage instruction, control bundle and datapath
//   ex_valid, ex_*        registered execute-stage copies of the id_* fields
//   load_use_stall        combinational; upstream PC and IF/ID must hold this cycle
//
// Configuration macro: ID_EX_LOAD_USE_EN (undefined -> load_use_stall tied 0).
module id_ex_reg #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic            id_branch,
  input  logic            id_memread,
  input  logic            id_memtoreg,
  input  logic            id_memwrite,
  input  logic            id_ALUsrc,
  input  logic            id_regwrite,
  input  logic [1:0]      id_ALUOp,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [3:0]      id_funct4,
  output logic            ex_valid,
  output logic            ex_branch,
  output logic            ex_memread,
  output logic            ex_memtoreg,
  output logic            ex_memwrite,
  output logic            ex_ALUsrc,
  output logic            ex_regwrite,
  output logic [1:0]      ex_ALUOp,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_funct4,
  output logic            load_use_stall
);

  logic hold;
  logic bubble;
  logic ctrl_en;

  // Load-use hazard: a load in EX whose rd is read by the instruction in ID.
  // rs2 is matched regardless of format, which is conservative but safe.
`ifdef ID_EX_LOAD_USE_EN
  assign load_use_stall = ex_valid & ex_memread & (ex_rd != 5'd0) & id_valid &
                          ((id_rs1 == ex_rd) | (id_rs2 == ex_rd)) & ~flush;
`else
  assign load_use_stall = 1'b0;
`endif

  // Flush overrides stall; a load-use bubble only applies when not held.
  assign hold    = stall & ~flush;
  assign bubble  = flush | load_use_stall;
  assign ctrl_en = id_valid & ~bubble;

  // Stage register; datapath fields load even for bubbles (no extra mux).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_branch   <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_ALUsrc   <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_ALUOp    <= 2'b00;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_rd       <= 5'd0;
      ex_funct4   <= 4'd0;
    end else if (!hold) begin
      ex_valid    <= ctrl_en;
      ex_branch   <= id_branch   & ctrl_en;
      ex_memread  <= id_memread  & ctrl_en;
      ex_memtoreg <= id_memtoreg & ctrl_en;
      ex_memwrite <= id_memwrite & ctrl_en;
      ex_ALUsrc   <= id_ALUsrc   & ctrl_en;
      ex_regwrite <= id_regwrite & ctrl_en;
      ex_ALUOp    <= id_ALUOp & {2{ctrl_en}};
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct4   <= id_funct4;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: self-checking bench for id_ex_reg with a scoreboard queue of
// expected execute-stage bundles. Expectations follow ID_EX_LOAD_USE_EN.
module tb_id_ex_reg;

  localparam int unsigned XLEN = 64;

  typedef struct packed {
    logic            valid;
    logic            branch;
    logic            memread;
    logic            memtoreg;
    logic            memwrite;
    logic            alusrc;
    logic            regwrite;
    logic [1:0]      aluop;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      funct4;
  } stage_t;

  localparam int unsigned SW = $bits(stage_t);

  logic   clk;
  logic   reset;
  logic   stall;
  logic   flush;
  stage_t id;
  stage_t m;
  stage_t sb[$];
  int     n_checks;
  int     n_fail;

  logic            ex_valid, ex_branch, ex_memread, ex_memtoreg;
  logic            ex_memwrite, ex_ALUsrc, ex_regwrite;
  logic [1:0]      ex_ALUOp;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [3:0]      ex_funct4;
  logic            load_use_stall;

  id_ex_reg #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id.valid), .id_branch(id.branch), .id_memread(id.memread),
    .id_memtoreg(id.memtoreg), .id_memwrite(id.memwrite),
    .id_ALUsrc(id.alusrc), .id_regwrite(id.regwrite), .id_ALUOp(id.aluop),
    .id_pc(id.pc), .id_rs1_data(id.rs1_data), .id_rs2_data(id.rs2_data),
    .id_imm(id.imm), .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
    .id_funct4(id.funct4),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_memread(ex_memread),
    .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
    .ex_ALUsrc(ex_ALUsrc), .ex_regwrite(ex_regwrite), .ex_ALUOp(ex_ALUOp),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct4(ex_funct4), .load_use_stall(load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic stage_t dut_ex();
    stage_t s;
    s = '{ex_valid, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_ALUsrc,
          ex_regwrite, ex_ALUOp, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
          ex_rs1, ex_rs2, ex_rd, ex_funct4};
    return s;
  endfunction

  // Bubble: no architectural side effect, datapath still taken from ID.
  function automatic stage_t bubble_of(input stage_t s);
    stage_t b;
    b = s;
    b.valid = 1'b0; b.branch = 1'b0; b.memread = 1'b0; b.memtoreg = 1'b0;
    b.memwrite = 1'b0; b.alusrc = 1'b0; b.regwrite = 1'b0; b.aluop = 2'b00;
    return b;
  endfunction

  function automatic stage_t loaded(input stage_t s);
    return s.valid ? s : bubble_of(s);
  endfunction

  function automatic logic exp_lus();
`ifdef ID_EX_LOAD_USE_EN
    return m.valid && m.memread && (m.rd != 5'd0) && id.valid &&
           ((id.rs1 == m.rd) || (id.rs2 == m.rd)) && !flush;
`else
    return 1'b0;
`endif
  endfunction

  function automatic stage_t rnd_stage();
    stage_t s;
    s.valid    = ($urandom_range(3) != 0);
    s.branch   = 1'($urandom);
    s.memread  = ($urandom_range(2) == 0);
    s.memtoreg = 1'($urandom);
    s.memwrite = 1'($urandom);
    s.alusrc   = 1'($urandom);
    s.regwrite = 1'($urandom);
    s.aluop    = 2'($urandom);
    s.pc       = {$urandom, $urandom};
    s.rs1_data = {$urandom, $urandom};
    s.rs2_data = {$urandom, $urandom};
    s.imm      = {$urandom, $urandom};
    s.rs1      = 5'($urandom_range(7));
    s.rs2      = 5'($urandom_range(7));
    s.rd       = 5'($urandom_range(7));
    s.funct4   = 4'($urandom);
    return s;
  endfunction

  // One cycle: drive ID, check the hazard output, push expected EX, compare after edge.
  task automatic step(input stage_t in, input logic st, input logic fl);
    logic   lus;
    stage_t nxt;
    id = in; stall = st; flush = fl;
    #1;
    lus = exp_lus();
    check("load_use_stall", SW'(load_use_stall), SW'(lus));
    if (fl || (!st && lus)) nxt = bubble_of(in);
    else if (st)            nxt = m;
    else                    nxt = loaded(in);
    sb.push_back(nxt);
    @(posedge clk);
    #1;
    m = sb.pop_front();
    check("ex_bundle", dut_ex(), m);
  endtask

  initial begin
    stage_t s, ld, add;
    n_checks = 0; n_fail = 0;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; id = '0; m = '0;
    #12;
    check("reset_bundle", dut_ex(), '0);
    check("reset_lus", SW'(load_use_stall), '0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // R-type pass-through
    s = '0; s.valid = 1'b1; s.regwrite = 1'b1; s.aluop = 2'b10; s.rd = 5'd5;
    s.rs1_data = 64'h10; s.rs1 = 5'd1; s.rs2 = 5'd2;
    step(s, 1'b0, 1'b0);
    check("rtype_rd", SW'(ex_rd), SW'(5'd5));
    check("rtype_rs1_data", SW'(ex_rs1_data), SW'(64'h10));
    check("rtype_aluop", SW'(ex_ALUOp), SW'(2'b10));
    check("rtype_valid_regwrite", SW'({ex_valid, ex_regwrite}), SW'(2'b11));

    // Load-use: ld x7 followed by add reading x7 through rs2
    ld = '0; ld.valid = 1'b1; ld.memread = 1'b1; ld.memtoreg = 1'b1;
    ld.regwrite = 1'b1; ld.alusrc = 1'b1; ld.rd = 5'd7; ld.rs1 = 5'd2;
    add = '0; add.valid = 1'b1; add.regwrite = 1'b1; add.aluop = 2'b10;
    add.rs1 = 5'd3; add.rs2 = 5'd7; add.rd = 5'd8; add.pc = 64'h104;
    step(ld, 1'b0, 1'b0);
    step(add, 1'b0, 1'b0);
`ifdef ID_EX_LOAD_USE_EN
    check("lu_bubble", SW'({ex_valid, ex_regwrite, ex_memread}), '0);
    check("lu_deassert", SW'(load_use_stall), '0);
    step(add, 1'b0, 1'b0);
`endif
    check("lu_add_loaded", SW'({ex_valid, ex_rd}), SW'({1'b1, 5'd8}));

    // Load to x0 never stalls
    ld.rd = 5'd0; add.rs2 = 5'd0;
    step(ld, 1'b0, 1'b0);
    step(add, 1'b0, 1'b0);
    check("x0_no_stall", SW'({ex_valid, ex_rd}), SW'({1'b1, 5'd8}));

    // Back-to-back loads to x9, then consumer
    ld.rd = 5'd9; add.rs1 = 5'd9; add.rs2 = 5'd3;
    step(ld, 1'b0, 1'b0);
    step(ld, 1'b0, 1'b0);
    step(add, 1'b0, 1'b0);
    step(add, 1'b0, 1'b0);
    check("b2b_add_loaded", SW'({ex_valid, ex_rd}), SW'({1'b1, 5'd8}));

    // Stall three cycles freezes contents; flush during stall bubbles
    for (int i = 0; i < 3; i++) step(rnd_stage(), 1'b1, 1'b0);
    check("stall_frozen_rd", SW'(ex_rd), SW'(5'd8));
    step(add, 1'b1, 1'b1);
    check("stall_flush_bubble", SW'({ex_valid, ex_regwrite}), '0);

    // Stall with a pending hazard: hold, then bubble, then consumer
    ld.rd = 5'd4; add.rs1 = 5'd4;
    step(ld, 1'b0, 1'b0);
    step(add, 1'b1, 1'b0);
    check("hazard_hold", SW'({ex_memread, ex_rd}), SW'({1'b1, 5'd4}));
    step(add, 1'b0, 1'b0);
    step(add, 1'b0, 1'b0);

    // Invalid instruction carrying memwrite
    s = '0; s.valid = 1'b0; s.memwrite = 1'b1; s.rd = 5'd3;
    step(s, 1'b0, 1'b0);
    check("invalid_memwrite", SW'({ex_valid, ex_memwrite}), '0);

    // Asynchronous reset mid-cycle during a stall
    step(ld, 1'b0, 1'b0);
    stall = 1'b1;
    #3 reset = 1'b1;
    #1;
    check("async_reset_bundle", dut_ex(), '0);
    check("async_reset_lus", SW'(load_use_stall), '0);
    m = '0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Random traffic, small register indices to provoke hazards
    for (int i = 0; i < 300; i++)
      step(rnd_stage(), ($urandom_range(5) == 0), ($urandom_range(7) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
